wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 150 +++++++++++++++
 tb/tb_wb_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: merges ALU results and aligned load data onto the single
// register-file write port, tracking at most one outstanding load.
//
// Handshakes:
//   - ALU: a result is consumed in any cycle where alu_valid && alu_ready. While
//     alu_ready is low the ALU keeps alu_rd/alu_result stable. alu_ready drops
//     only when a load completes that same cycle.
//   - Load request: a request is taken when ld_req_valid && ld_req_ready.
//     Illegal requests are never accepted. Instead they produce a one-cycle
//     ld_fault.
//   - Memory: mem_rvalid is a single-cycle pulse. It only has an effect while
//     a load is outstanding.
//
// FSM state is visible through ld_busy (high in WAIT) and ld_busy_rd.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module wb_stage #(
  parameter int WORD_WIDTH    = `WORD_WIDTH,
  parameter int RF_ADDR_WIDTH = `RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [RF_ADDR_WIDTH-1:0] alu_rd,
  input  logic [WORD_WIDTH-1:0]    alu_result,
  output logic                     alu_ready,
  input  logic                     ld_req_valid,
  output logic                     ld_req_ready,
  input  logic [RF_ADDR_WIDTH-1:0] ld_rd,
  input  logic [2:0]               ld_funct3,
  input  logic [1:0]               ld_addr_lo,
  input  logic                     mem_rvalid,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  output logic                     regWrite,
  output logic [RF_ADDR_WIDTH-1:0] writeAddr,
  output logic [WORD_WIDTH-1:0]    dataIn,
  output logic                     ld_busy,
  output logic [RF_ADDR_WIDTH-1:0] ld_busy_rd,
  output logic                     ld_fault
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                  state;
  logic [2:0]              cap_funct3;
  logic [1:0]              cap_lo;
  logic                    ld_legal;
  logic                    ld_done;
  logic                    alu_accept;
  logic [7:0]              sel_byte;
  logic [15:0]             sel_half;
  logic [WORD_WIDTH-1:0]   ld_data;

  // Load legality: known funct3 and natural alignment for its access size.
  always_comb begin
    ld_legal = 1'b0;
    case (ld_funct3)
      3'b000, 3'b100: ld_legal = 1'b1;
      3'b001, 3'b101: ld_legal = ~ld_addr_lo[0];
      3'b010:         ld_legal = (ld_addr_lo == 2'b00);
      default:        ld_legal = 1'b0;
    endcase
  end

  assign ld_req_ready = (state == S_IDLE);
  assign ld_busy      = (state == S_WAIT);
  assign ld_done      = (state == S_WAIT) && mem_rvalid;
  // A completing load owns the write port, so the ALU is stalled that cycle.
  assign alu_ready    = ~ld_done;
  assign alu_accept   = alu_valid && alu_ready;

  // Extract and extend the loaded field using the offset captured at acceptance.
  always_comb begin
    sel_byte = 8'h00;
    case (cap_lo)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = cap_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data  = mem_rdata;
    case (cap_funct3)
      3'b000:  ld_data = {{(WORD_WIDTH-8){sel_byte[7]}}, sel_byte};
      3'b100:  ld_data = {{(WORD_WIDTH-8){1'b0}}, sel_byte};
      3'b001:  ld_data = {{(WORD_WIDTH-16){sel_half[15]}}, sel_half};
      3'b101:  ld_data = {{(WORD_WIDTH-16){1'b0}}, sel_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Load FSM plus the registered write port and fault pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cap_funct3 <= 3'b000;
      cap_lo     <= 2'b00;
      ld_busy_rd <= '0;
      ld_fault   <= 1'b0;
      regWrite   <= 1'b0;
      writeAddr  <= '0;
      dataIn     <= '0;
    end else begin
      regWrite <= 1'b0;
      ld_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_req_valid) begin
            if (ld_legal) begin
              state      <= S_WAIT;
              ld_busy_rd <= ld_rd;
              cap_funct3 <= ld_funct3;
              cap_lo     <= ld_addr_lo;
            end else begin
              ld_fault <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state      <= S_IDLE;
            ld_busy_rd <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
      // x0 destinations consume the source but never pulse regWrite.
      if (ld_done) begin
        if (ld_busy_rd != '0) begin
          regWrite  <= 1'b1;
          writeAddr <= ld_busy_rd;
          dataIn    <= ld_data;
        end
      end else if (alu_accept && (alu_rd != '0)) begin
        regWrite  <= 1'b1;
        writeAddr <= alu_rd;
        dataIn    <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] dataIn;
  logic        ld_busy;
  logic [4:0]  ld_busy_rd;
  logic        ld_fault;

  int total = 0;
  int bad   = 0;

  // Reference model: one pending load descriptor plus the expected writes.
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  bit          m_fault;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  bit          alu_stalled;
  logic [36:0] exp_q[$];

  wb_stage #(.WORD_WIDTH(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .regWrite(regWrite), .writeAddr(writeAddr), .dataIn(dataIn),
    .ld_busy(ld_busy), .ld_busy_rd(ld_busy_rd), .ld_fault(ld_fault)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Legal = known load type and address a multiple of the access size.
  function automatic bit is_legal(input logic [2:0] f3, input logic [1:0] lo);
    int size;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    size = 1 << f3[1:0];
    return (int'(lo) % size) == 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_req_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  // One clock: check handshake outputs, advance model, check registered outputs.
  task automatic cycle();
    logic exp_ar;
    logic [36:0] e;
    #1;
    exp_ar = !(m_busy && mem_rvalid);
    chk("alu_ready", alu_ready, exp_ar);
    chk("ld_req_ready", ld_req_ready, !m_busy);
    alu_stalled = alu_valid && !exp_ar;
    m_fault = 0;
    if (m_busy && mem_rvalid) begin
      if (m_rd != 0) exp_q.push_back({m_rd, load_value(m_f3, m_lo, mem_rdata)});
      m_busy = 0;
    end else begin
      if (alu_valid && alu_rd != 0) exp_q.push_back({alu_rd, alu_result});
      if (!m_busy && ld_req_valid) begin
        if (is_legal(ld_funct3, ld_addr_lo)) begin
          m_busy = 1; m_rd = ld_rd; m_f3 = ld_funct3; m_lo = ld_addr_lo;
        end else begin
          m_fault = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("regWrite", regWrite, 1);
      chk("writeAddr", writeAddr, e[36:32]);
      chk("dataIn", dataIn, e[31:0]);
      last_addr = e[36:32];
      last_data = e[31:0];
    end else begin
      chk("regWrite_idle", regWrite, 0);
      chk("writeAddr_hold", writeAddr, last_addr);
      chk("dataIn_hold", dataIn, last_data);
    end
    chk("ld_busy", ld_busy, m_busy);
    chk("ld_busy_rd", ld_busy_rd, m_busy ? m_rd : 5'd0);
    chk("ld_fault", ld_fault, m_fault);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_regWrite"}, regWrite, 0);
    chk({tag, "_writeAddr"}, writeAddr, 0);
    chk({tag, "_dataIn"}, dataIn, 0);
    chk({tag, "_ld_busy"}, ld_busy, 0);
    chk({tag, "_ld_busy_rd"}, ld_busy_rd, 0);
    chk({tag, "_ld_fault"}, ld_fault, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    rst_n = 1;
    m_busy = 0; m_fault = 0; alu_stalled = 0;
    last_addr = 0; last_data = 0;
    exp_q.delete();
    #1;
    chk("post_rst_ld_req_ready", ld_req_ready, 1);
    chk("post_rst_alu_ready", alu_ready, 1);
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [4:0] rd, input logic [1:0] lo);
    set_idle();
    ld_req_valid = 1; ld_funct3 = f3; ld_rd = rd; ld_addr_lo = lo;
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    do_reset();

    // ALU write to x5.
    set_idle(); alu_valid = 1; alu_rd = 5; alu_result = 32'h1234;
    cycle();
    chk("alu_x5_we", regWrite, 1);
    chk("alu_x5_addr", writeAddr, 5);
    chk("alu_x5_data", dataIn, 32'h0000_1234);
    set_idle(); cycle();

    // LB / LBU from byte 2.
    drive_load(3'b000, 3, 2); cycle();
    set_idle(); cycle();
    mem_rvalid = 1; mem_rdata = 32'h0080_FF00; cycle();
    chk("lb_data", dataIn, 32'hFFFF_FF80);
    drive_load(3'b100, 3, 2); cycle();
    set_idle(); mem_rvalid = 1; mem_rdata = 32'h0080_FF00; cycle();
    chk("lbu_data", dataIn, 32'h0000_0080);

    // LH completes alongside an ALU result; ALU waits one cycle.
    drive_load(3'b001, 7, 2); cycle();
    set_idle(); mem_rvalid = 1; mem_rdata = 32'h8001_0000;
    alu_valid = 1; alu_rd = 9; alu_result = 32'h55;
    #1;
    chk("arb_alu_ready", alu_ready, 0);
    cycle();
    chk("lh_addr", writeAddr, 7);
    chk("lh_data", dataIn, 32'hFFFF_8001);
    mem_rvalid = 0; cycle();
    chk("arb_alu_addr", writeAddr, 9);
    chk("arb_alu_data", dataIn, 32'h55);

    // Illegal loads.
    drive_load(3'b010, 4, 1); cycle();
    chk("lw_mis_fault", ld_fault, 1);
    chk("lw_mis_ready", ld_req_ready, 1);
    chk("lw_mis_we", regWrite, 0);
    drive_load(3'b011, 4, 0); cycle();
    chk("f3_011_fault", ld_fault, 1);
    chk("f3_011_ready", ld_req_ready, 1);
    set_idle(); cycle();
    chk("fault_one_cycle", ld_fault, 0);

    // Reset while a load is outstanding.
    drive_load(3'b010, 4, 0); cycle();
    chk("wait_busy", ld_busy, 1);
    chk("wait_busy_rd", ld_busy_rd, 4);
    set_idle(); cycle();
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; cycle();
    chk("abandon_we", regWrite, 0);
    chk("abandon_busy", ld_busy, 0);

    // x0 destinations.
    drive_load(3'b010, 0, 0); cycle();
    set_idle(); mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; cycle();
    chk("x0_ld_we", regWrite, 0);
    chk("x0_ld_idle", ld_req_ready, 1);
    set_idle(); alu_valid = 1; alu_rd = 0; alu_result = 32'h77; cycle();
    chk("x0_alu_we", regWrite, 0);

    // Randomized traffic, ALU inputs held while stalled.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      if (!alu_stalled) begin
        alu_valid  = ($urandom_range(0, 1) == 1);
        alu_rd     = 5'($urandom_range(0, 31));
        alu_result = $urandom;
      end
      ld_req_valid = ($urandom_range(0, 2) == 0);
      ld_rd        = 5'($urandom_range(0, 31));
      ld_funct3    = 3'($urandom_range(0, 7));
      ld_addr_lo   = 2'($urandom_range(0, 3));
      mem_rvalid   = ($urandom_range(0, 2) == 0);
      mem_rdata    = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
